cache_axi_bridge: RTL and testbench

- Memory-side responder for the cache/uncache request interface. The I-side and D-side selectors drive that interface: rd_req/rd_type/rd_addr, wr_req/wr_type/wr_addr/wr_wstrb, plus data handshakes.
- The bridge accepts one read and one write transaction at a time and turns each into an AXI3/4 read burst (AR/R) or write burst (AW/W/B).
- Read data returns to the requester word by word on ret_valid/ret_last.
- One instance sits between each cache_select mux output and the AXI crossbar.

---
 rtl/cache_axi_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache/uncache request interface to AXI burst bridge
//
// Purpose: accepts one read and one write request at a time from the cache
// select mux and turns each into an AXI INCR burst. Read data is passed back
// word by word; a read to the line of an in-flight write waits until the
// write response has been received.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr     read request; rd_rdy accepts it
//   ret_valid/ret_last/ret_data read return stream (pass-through of R channel)
//   wr_req/wr_type/wr_addr     write request with wr_wstrb and wr_data line buffer;
//                              wr_rdy accepts it
//   ar*/r*                     AXI read address and read data channels
//   aw*/w*/b*                  AXI write address, write data and response channels
module cache_axi_bridge #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] RID_VAL    = 4'd0,
  parameter logic [3:0] WID_VAL    = 4'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req,
  input  logic [2:0]                rd_type,
  input  logic [31:0]               rd_addr,
  output logic                      rd_rdy,
  output logic                      ret_valid,
  output logic                      ret_last,
  output logic [31:0]               ret_data,
  input  logic                      wr_req,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  wr_data,
  output logic                      wr_rdy,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [3:0]                awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [3:0]                wid,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [3:0]                bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int         OFF      = $clog2(4 * LINE_WORDS);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);
  localparam logic [2:0] T_LINE   = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [31:0]              r_addr;
  logic [2:0]               r_type;
  logic [31:0]              w_addr;
  logic [2:0]               w_type;
  logic [3:0]               w_strb;
  logic [32*LINE_WORDS-1:0] w_buf;
  logic [7:0]               cnt;
  logic                     hazard;

  // Only one transaction per channel is ever outstanding, so IDs and
  // response codes carry no information for this bridge.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, bid, bresp};

  // A read must not overtake a write to the same line: either one already in
  // flight, or one being accepted this very cycle (the write wins).
  assign wr_rdy = (w_state == W_IDLE);
  assign hazard = ((w_state != W_IDLE) && (rd_addr[31:OFF] == w_addr[31:OFF])) ||
                  (wr_req && wr_rdy && (rd_addr[31:OFF] == wr_addr[31:OFF]));

  assign arid    = RID_VAL;
  assign araddr  = r_addr;
  assign arlen   = (r_type == T_LINE) ? LINE_LEN : 8'd0;
  assign arsize  = (r_type == T_LINE) ? 3'd2 : {1'b0, r_type[1:0]};
  assign arburst = 2'b01;

  assign awid    = WID_VAL;
  assign wid     = WID_VAL;
  assign awaddr  = w_addr;
  assign awlen   = (w_type == T_LINE) ? LINE_LEN : 8'd0;
  assign awsize  = (w_type == T_LINE) ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst = 2'b01;
  assign wstrb   = (w_type == T_LINE) ? 4'hF : w_strb;
  assign wlast   = (cnt == awlen);

  assign ret_data = rdata;

  always_comb begin
    wdata = 32'd0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (cnt == 8'(i)) wdata = w_buf[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= 32'd0;
      r_type  <= 3'd0;
    end else begin
      r_state <= r_next;
      if (rd_req && rd_rdy) begin
        r_addr <= rd_addr;
        r_type <= rd_type;
      end
    end
  end

  always_comb begin
    r_next    = r_state;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    case (r_state)
      R_IDLE: begin
        rd_rdy = !hazard;
        if (rd_req && !hazard) r_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rlast;
        if (rvalid && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= 32'd0;
      w_type  <= 3'd0;
      w_strb  <= 4'd0;
      w_buf   <= '0;
      cnt     <= 8'd0;
    end else begin
      w_state <= w_next;
      if (wr_req && wr_rdy) begin
        w_addr <= wr_addr;
        w_type <= wr_type;
        w_strb <= wr_wstrb;
        w_buf  <= wr_data;
      end
      if (wvalid && wready) begin
        cnt <= wlast ? 8'd0 : cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next  = w_state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (w_state)
      W_IDLE: if (wr_req) w_next = W_AW;
      W_AW: begin
        awvalid = 1'b1;
        if (awready) w_next = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - randomized bench for cache_axi_bridge with memory reference model
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  always #5 clk = ~clk;

  cache_axi_bridge #(.LINE_WORDS(4), .RID_VAL(4'd0), .WID_VAL(4'd1)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  int total = 0;
  int bad   = 0;

  // reference memory (updated when a write is accepted) and slave memory
  // (updated by actual W beats)
  logic [31:0] rmem [32];
  logic [31:0] smem [32];
  ax_t   exp_ar[$], exp_aw[$];
  beat_t exp_ret[$], exp_w[$], srq[$];

  bit          rd_busy, wr_busy, r_phase, aw_done, b_pend, stop, force_rd, rd_clear;
  int          rd_line, s_widx, ret_cnt;
  logic [31:0] wr_line_addr, s_aw_addr;
  logic [2:0]  types [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(logic [31:0] a);
    return int'(a[6:2]);
  endfunction

  function automatic logic [27:0] tag_of(logic [31:0] a);
    return a[31:4];
  endfunction

  function automatic logic [2:0] size_of(logic [2:0] ty);
    return (ty == 3'd4) ? 3'd2 : {1'b0, ty[1:0]};
  endfunction

  function automatic logic [31:0] mk_addr(int line, logic [2:0] ty);
    logic [31:0] a;
    a = 32'h1000 + 32'(line) * 32'd16;
    case (ty)
      3'd0:    a += 32'($urandom % 16);
      3'd1:    a += 32'(2 * ($urandom % 8));
      3'd2:    a += 32'(4 * ($urandom % 4));
      default: ;
    endcase
    return a;
  endfunction

  task automatic drive();
    logic [2:0] ty;
    int         l;
    if (rd_clear) begin
      rd_req   = 1'b0;
      rd_clear = 1'b0;
    end
    if (force_rd && !rd_req) begin
      rd_type  = 3'd4;
      rd_addr  = 32'h1000;
      rd_req   = 1'b1;
      force_rd = 1'b0;
    end else if (!stop && !rd_req && !rd_busy && ($urandom % 3 == 0)) begin
      ty      = types[$urandom % 4];
      rd_type = ty;
      rd_addr = mk_addr(int'($urandom % 8), ty);
      rd_req  = 1'b1;
    end
    wr_req = 1'b0;
    if (!stop && !wr_busy && ($urandom % 4 == 0)) begin
      l = int'($urandom % 8);
      if (!(rd_busy && l == rd_line)) begin
        ty      = types[$urandom % 4];
        wr_type = ty;
        wr_addr = mk_addr(l, ty);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        case (ty)
          3'd0:    wr_wstrb = 4'b0001 << wr_addr[1:0];
          3'd1:    wr_wstrb = wr_addr[1] ? 4'b1100 : 4'b0011;
          3'd2:    wr_wstrb = 4'hF;
          default: wr_wstrb = 4'($urandom);
        endcase
        wr_req = 1'b1;
      end
    end
    arready = 1'($urandom % 2);
    awready = ($urandom % 3) != 0;
    wready  = 1'($urandom % 2);
    if (srq.size() > 0 && ($urandom % 4 != 0)) begin
      rvalid = 1'b1;
      rdata  = srq[0].data;
      rlast  = srq[0].last;
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
      rlast  = 1'($urandom % 2);
    end
    bvalid = b_pend && ($urandom % 2 == 1);
    rid    = 4'($urandom);
    rresp  = 2'($urandom);
    bid    = 4'($urandom);
    bresp  = 2'($urandom);
  endtask

  task automatic evaluate();
    bit          exp_rr;
    int          base;
    logic [31:0] m;
    exp_rr = !rd_busy &&
             !(wr_busy && tag_of(rd_addr) == tag_of(wr_line_addr)) &&
             !(wr_req && !wr_busy && tag_of(rd_addr) == tag_of(wr_addr));
    check("rd_rdy", rd_rdy, exp_rr);
    check("wr_rdy", wr_rdy, !wr_busy);
    check("arvalid", arvalid, exp_ar.size() > 0);
    if (arvalid && exp_ar.size() > 0) begin
      check("araddr", araddr, exp_ar[0].addr);
      check("arlen", arlen, exp_ar[0].len);
      check("arsize", arsize, exp_ar[0].size);
      check("arburst", arburst, 2'b01);
      check("arid", arid, 4'd0);
    end
    check("rready", rready, r_phase);
    check("ret_valid", ret_valid, rvalid);
    if (ret_valid) begin
      ret_cnt++;
      if (exp_ret.size() == 0) begin
        check("ret_spurious", 1, 0);
      end else begin
        check("ret_data", ret_data, exp_ret[0].data);
        check("ret_last", ret_last, exp_ret[0].last);
        void'(exp_ret.pop_front());
      end
    end
    check("awvalid", awvalid, exp_aw.size() > 0);
    if (awvalid && exp_aw.size() > 0) begin
      check("awaddr", awaddr, exp_aw[0].addr);
      check("awlen", awlen, exp_aw[0].len);
      check("awsize", awsize, exp_aw[0].size);
      check("awburst", awburst, 2'b01);
      check("awid", awid, 4'd1);
    end
    check("wvalid", wvalid, aw_done && exp_w.size() > 0);
    if (wvalid && exp_w.size() > 0) begin
      check("wdata", wdata, exp_w[0].data);
      check("wstrb", wstrb, exp_w[0].strb);
      check("wlast", wlast, exp_w[0].last);
      check("wid", wid, 4'd1);
    end
    check("bready", bready, b_pend);

    if (rd_req && rd_rdy) begin
      exp_ar.push_back('{rd_addr, (rd_type == 3'd4) ? 8'd3 : 8'd0, size_of(rd_type)});
      if (rd_type == 3'd4) begin
        base = widx(rd_addr);
        for (int i = 0; i < 4; i++) exp_ret.push_back('{rmem[base + i], 4'hF, i == 3});
      end else begin
        exp_ret.push_back('{rmem[widx(rd_addr)], 4'hF, 1'b1});
      end
      rd_busy  = 1'b1;
      rd_line  = int'(rd_addr[6:4]);
      rd_clear = 1'b1;
    end
    if (wr_req && wr_rdy) begin
      exp_aw.push_back('{wr_addr, (wr_type == 3'd4) ? 8'd3 : 8'd0, size_of(wr_type)});
      base = widx(wr_addr);
      if (wr_type == 3'd4) begin
        for (int i = 0; i < 4; i++) begin
          rmem[base + i] = wr_data[32*i +: 32];
          exp_w.push_back('{wr_data[32*i +: 32], 4'hF, i == 3});
        end
      end else begin
        m = rmem[base];
        for (int b = 0; b < 4; b++) if (wr_wstrb[b]) m[8*b +: 8] = wr_data[8*b +: 8];
        rmem[base] = m;
        exp_w.push_back('{wr_data[31:0], wr_wstrb, 1'b1});
      end
      wr_busy      = 1'b1;
      wr_line_addr = wr_addr;
    end
    if (arvalid && arready) begin
      if (exp_ar.size() > 0) void'(exp_ar.pop_front());
      for (int i = 0; i <= int'(arlen); i++)
        srq.push_back('{smem[(widx(araddr) + i) % 32], 4'hF, i == int'(arlen)});
      r_phase = 1'b1;
    end
    if (rvalid && rready) begin
      if (srq.size() > 0) void'(srq.pop_front());
      if (rlast) begin
        rd_busy = 1'b0;
        r_phase = 1'b0;
      end
    end
    if (awvalid && awready) begin
      if (exp_aw.size() > 0) void'(exp_aw.pop_front());
      s_aw_addr = awaddr;
      s_widx    = 0;
      aw_done   = 1'b1;
    end
    if (wvalid && wready) begin
      base = (widx(s_aw_addr) + s_widx) % 32;
      m = smem[base];
      for (int b = 0; b < 4; b++) if (wstrb[b]) m[8*b +: 8] = wdata[8*b +: 8];
      smem[base] = m;
      s_widx++;
      if (exp_w.size() > 0) void'(exp_w.pop_front());
      if (wlast) begin
        b_pend  = 1'b1;
        aw_done = 1'b0;
      end
    end
    if (bvalid && bready) begin
      b_pend  = 1'b0;
      wr_busy = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    evaluate();
  endtask

  task automatic check_idle_outputs(string pfx);
    check({pfx, "_arvalid"}, arvalid, 1'b0);
    check({pfx, "_awvalid"}, awvalid, 1'b0);
    check({pfx, "_wvalid"}, wvalid, 1'b0);
    check({pfx, "_rready"}, rready, 1'b0);
    check({pfx, "_bready"}, bready, 1'b0);
    check({pfx, "_ret_valid"}, ret_valid, 1'b0);
    check({pfx, "_ret_last"}, ret_last, 1'b0);
    check({pfx, "_rd_rdy"}, rd_rdy, 1'b1);
    check({pfx, "_wr_rdy"}, wr_rdy, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 32'h1000;
    wr_req = 0; wr_type = 0; wr_addr = 32'h1040; wr_wstrb = 0; wr_data = '0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    stop = 1; force_rd = 0; rd_clear = 0;
    rd_busy = 0; wr_busy = 0; r_phase = 0; aw_done = 0; b_pend = 0;
    rd_line = -1; s_widx = 0; ret_cnt = 0; wr_line_addr = 0; s_aw_addr = 0;
    for (int i = 0; i < 32; i++) begin
      rmem[i] = $urandom;
      smem[i] = rmem[i];
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    rlast = 1'b1;
    #1;
    check_idle_outputs("reset");

    stop = 0;
    repeat (3000) cycle();
    stop = 1;
    n = 0;
    while ((rd_busy || wr_busy || rd_req) && n < 500) begin
      cycle();
      n++;
    end
    check("drain_busy", {rd_busy, wr_busy, rd_req}, 3'b000);
    check("drain_ret_left", exp_ret.size(), 0);
    check("drain_w_left", exp_w.size(), 0);

    force_rd = 1;
    ret_cnt  = 0;
    n = 0;
    while (ret_cnt < 2 && n < 300) begin
      cycle();
      n++;
    end
    check("midburst_beats", ret_cnt, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rvalid = 1'b1;
    rlast  = 1'b1;
    #1;
    check_idle_outputs("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
